// File: rtl/aligner_pkg.sv
// Shared constants, state type and helpers for the symbol aligner.
//   COMMA_NEG / COMMA_POS : 7-bit comma prefixes (K28.x, both disparities)
//   K28_5_NEG / K28_5_POS : full K28.5 code groups
//   align_state_e         : aligner FSM states
//   is_comma()            : true when a 10-bit candidate starts with a comma prefix
//   cand_at()             : candidate symbol at offset k of a 20-bit window
//   sat_inc4()            : 4-bit increment saturating at 15
package aligner_pkg;

  localparam logic [6:0] COMMA_NEG = 7'b0011111;
  localparam logic [6:0] COMMA_POS = 7'b1100000;
  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StChecking = 2'd1,
    StLocked   = 2'd2
  } align_state_e;

  function automatic logic is_comma(input logic [9:0] sym);
    return (sym[9:3] == COMMA_NEG) || (sym[9:3] == COMMA_POS);
  endfunction

  // Window bit 19 is the earliest bit; candidate k starts k bits later.
  function automatic logic [9:0] cand_at(input logic [19:0] w, input logic [3:0] k);
    logic [19:0] s;
    s = w << k;
    return s[19:10];
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma search over a 20-bit window.
//   win   in  20  {previous word, current word}, bit 19 earliest
//   hit   out 10  hit[k] set when the candidate at offset k is a comma
//   index out 4   lowest k with a hit (0 when there is none)
module comma_detect
  import aligner_pkg::*;
(
  input  logic [19:0] win,
  output logic [9:0]  hit,
  output logic [3:0]  index
);

  always_comb begin
    hit = '0;
    for (int k = 0; k < 10; k++) begin
      hit[k] = is_comma(cand_at(win, 4'(k)));
    end
  end

  // Scan downwards so the lowest hitting offset is the last assignment.
  always_comb begin
    index = '0;
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) index = 4'(k);
    end
  end

endmodule

// File: rtl/symbol_aligner.sv
// Recovers 10-bit symbol boundaries from raw SERDES words and emits aligned
// symbols to the 8b/10b decoder (INTERCLK domain).
//   INTERCLK    in   1   symbol clock, rising edge
//   Reset       in   1   asynchronous, active-low
//   iData       in   10  raw word, bit 9 received first
//   oData       out  10  aligned symbol (bit 9 = 'a')
//   oValid      out  1   oData comes from a locked boundary
//   LOCKED      out  1   FSM is locked
//   COMMA_DET   out  1   oData is a comma
//   oOffset     out  4   boundary offset in force, 0..9
//   LOSS_EVENTS out  8   lock-loss count, saturating (only with SYMBOL_ALIGNER_STATS_EN)
// Optional feature macro: SYMBOL_ALIGNER_STATS_EN.
module symbol_aligner
  import aligner_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic       INTERCLK,
  input  logic       Reset,
  input  logic [9:0] iData,
  output logic [9:0] oData,
  output logic       oValid,
  output logic       LOCKED,
  output logic       COMMA_DET,
`ifdef SYMBOL_ALIGNER_STATS_EN
  output logic [7:0] LOSS_EVENTS,
`endif
  output logic [3:0] oOffset
);

  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_CNT);

  align_state_e state_q, state_d;
  logic [9:0]   prev_q;
  logic [3:0]   offset_q, offset_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   mis_q, mis_d;
  logic [9:0]   odata_q, odata_d;
  logic         comma_q, comma_d;
  logic         locked_q, locked_d;

  logic [19:0]  win;
  logic [9:0]   hit;
  logic [3:0]   hit_idx;
  logic         any_hit;

  assign win     = {prev_q, iData};
  assign any_hit = |hit;

  comma_detect u_comma_detect (
    .win   (win),
    .hit   (hit),
    .index (hit_idx)
  );

  // State register
  always_ff @(posedge INTERCLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StUnlocked;
      prev_q   <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      mis_q    <= '0;
      odata_q  <= '0;
      comma_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= iData;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
      odata_q  <= odata_d;
      comma_q  <= comma_d;
      locked_q <= locked_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    mis_d    = mis_q;
    unique case (state_q)
      StUnlocked: begin
        if (any_hit) begin
          offset_d = hit_idx;
          cnt_d    = 4'd1;
          if (LockCnt <= 4'd1) begin
            state_d = StLocked;
            mis_d   = '0;
          end else begin
            state_d = StChecking;
          end
        end
      end
      StChecking: begin
        if (hit[offset_q]) begin
          cnt_d = sat_inc4(cnt_q);
          if (cnt_d >= LockCnt) begin
            state_d = StLocked;
            mis_d   = '0;
          end
        end else if (any_hit) begin
          offset_d = hit_idx;
          cnt_d    = 4'd1;
        end
      end
      StLocked: begin
        // A comma at the locked offset wins over any foreign one.
        if (hit[offset_q]) begin
          mis_d = '0;
        end else if (any_hit) begin
          mis_d = sat_inc4(mis_q);
          if (mis_d >= LossCnt) begin
            state_d = StUnlocked;
            cnt_d   = '0;
            mis_d   = '0;
          end
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Output next values use the offset in force after this edge, so a comma
  // that moves the boundary is itself emitted aligned.
  always_comb begin
    odata_d  = cand_at(win, offset_d);
    comma_d  = hit[offset_d];
    locked_d = (state_d == StLocked);
  end

  assign oData     = odata_q;
  assign COMMA_DET = comma_q;
  assign LOCKED    = locked_q;
  assign oValid    = locked_q;
  assign oOffset   = offset_q;

`ifdef SYMBOL_ALIGNER_STATS_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  assign loss_evt = (state_q == StLocked) && (state_d == StUnlocked);

  always_ff @(posedge INTERCLK or negedge Reset) begin
    if (!Reset) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != 8'hff)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign LOSS_EVENTS = loss_q;
`endif

endmodule

// File: tb/tb_symbol_aligner.sv
// Directed bench for symbol_aligner (LOCK_CNT=3, LOSS_CNT=4). Symbols are
// serialised into a bit queue; leftover bits in the queue set the offset at
// which each symbol appears, and each symbol is judged on the edge after the
// one that carried its last bits.
module tb_symbol_aligner;
  import aligner_pkg::*;

  localparam logic [9:0] Fill = 10'b1010101010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] idata = '0;
  logic [9:0] odata;
  logic       ovalid, locked, comma_det;
  logic [3:0] ooffset;
`ifdef SYMBOL_ALIGNER_STATS_EN
  logic [7:0] loss_events;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        bitq[$];
  logic        neg_next = 1'b1;
  logic [9:0]  last_comma = '0;
  logic [9:0]  pay[5];

  always #2 clk = ~clk;

  symbol_aligner #(
    .LOCK_CNT (3),
    .LOSS_CNT (4)
  ) dut (
    .INTERCLK    (clk),
    .Reset       (rst_n),
    .iData       (idata),
    .oData       (odata),
    .oValid      (ovalid),
    .LOCKED      (locked),
    .COMMA_DET   (comma_det),
`ifdef SYMBOL_ALIGNER_STATS_EN
    .LOSS_EVENTS (loss_events),
`endif
    .oOffset     (ooffset)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Append the n low bits of 'bits', most significant first.
  task automatic push_bits(input logic [9:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(bits[i]);
  endtask

  task automatic emit();
    logic [9:0] w;
    for (int i = 9; i >= 0; i--) w[i] = bitq.pop_front();
    idata = w;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [9:0] sym);
    push_bits(sym, 10);
    emit();
  endtask

  task automatic next_comma(output logic [9:0] c);
    c = neg_next ? K28_5_NEG : K28_5_POS;
    neg_next = ~neg_next;
  endtask

  task automatic fills(input int n);
    for (int i = 0; i < n; i++) feed(Fill);
  endtask

  // Send a comma, then one filler so the comma's window is judged.
  task automatic comma_then_eval();
    next_comma(last_comma);
    feed(last_comma);
    feed(Fill);
  endtask

  task automatic restart(input int slip);
    rst_n = 1'b0;
    idata = '0;
    #1;
    rst_n = 1'b1;
    bitq.delete();
    neg_next = 1'b1;
    for (int i = 0; i < slip; i++) bitq.push_back(i[0] ? 1'b0 : 1'b1);
  endtask

  initial begin
    logic [9:0] c;
    pay[0] = 10'b1001110100;
    pay[1] = 10'b0110001011;
    pay[2] = 10'b1011001001;
    pay[3] = 10'b0101010101;
    pay[4] = Fill;

    // Reset state
    #1;
    check("rst_odata", 32'(odata), 32'h0);
    check("rst_valid", 32'(ovalid), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_comma", 32'(comma_det), 32'h0);
    check("rst_offset", 32'(ooffset), 32'h0);
    #3;
    rst_n = 1'b1;
    push_bits(10'b101, 3);

    // 1: acquire at offset 3
    fills(3);
    comma_then_eval();
    check("t1_c1_locked", 32'(locked), 32'h0);
    check("t1_c1_offset", 32'(ooffset), 32'h3);
    check("t1_c1_comma", 32'(comma_det), 32'h1);
    fills(2);
    comma_then_eval();
    check("t1_c2_locked", 32'(locked), 32'h0);
    fills(2);
    comma_then_eval();
    check("t1_locked", 32'(locked), 32'h1);
    check("t1_valid", 32'(ovalid), 32'h1);
    check("t1_offset", 32'(ooffset), 32'h3);
    check("t1_odata", 32'(odata), 32'(last_comma));
    check("t1_comma", 32'(comma_det), 32'h1);
    feed(Fill);
    check("t1_fill_odata", 32'(odata), 32'(Fill));
    check("t1_fill_comma", 32'(comma_det), 32'h0);

    // 2: one foreign comma at offset 5, then an aligned one
    next_comma(c);
    push_bits(10'b10, 2);
    push_bits(c, 10);
    push_bits(10'b10101010, 8);
    emit();
    emit();
    check("t2_locked", 32'(locked), 32'h1);
    check("t2_offset", 32'(ooffset), 32'h3);
    check("t2_comma", 32'(comma_det), 32'h0);
    fills(2);
    comma_then_eval();
    check("t2_realign_locked", 32'(locked), 32'h1);
    check("t2_realign_comma", 32'(comma_det), 32'h1);

    // 3: permanent slip to offset 5 -> loss after 4, re-lock after 3 more
    push_bits(10'b10, 2);
    for (int i = 1; i <= 4; i++) begin
      fills(2);
      comma_then_eval();
      if (i == 3) check("t3_mis3_locked", 32'(locked), 32'h1);
    end
    check("t3_loss_locked", 32'(locked), 32'h0);
    check("t3_loss_valid", 32'(ovalid), 32'h0);
    check("t3_loss_offset", 32'(ooffset), 32'h3);
    for (int i = 1; i <= 3; i++) begin
      fills(2);
      comma_then_eval();
      if (i == 1) begin
        check("t3_acq_offset", 32'(ooffset), 32'h5);
        check("t3_acq_comma", 32'(comma_det), 32'h1);
        check("t3_acq_locked", 32'(locked), 32'h0);
      end
    end
    check("t3_relock", 32'(locked), 32'h1);
    check("t3_relock_offset", 32'(ooffset), 32'h5);
    check("t3_relock_odata", 32'(odata), 32'(last_comma));
`ifdef SYMBOL_ALIGNER_STATS_EN
    check("t3_loss_events", 32'(loss_events), 32'h1);
`endif

    // 4: CHECKING at 3, then a comma at 6 restarts the count
    restart(3);
    fills(3);
    comma_then_eval();
    fills(2);
    comma_then_eval();
    check("t4_cnt2_locked", 32'(locked), 32'h0);
    check("t4_cnt2_offset", 32'(ooffset), 32'h3);
    push_bits(10'b101, 3);
    fills(2);
    comma_then_eval();
    check("t4_move_offset", 32'(ooffset), 32'h6);
    check("t4_move_comma", 32'(comma_det), 32'h1);
    check("t4_move_odata", 32'(odata), 32'(last_comma));
    fills(2);
    comma_then_eval();
    check("t4_cnt2b_locked", 32'(locked), 32'h0);
    fills(2);
    comma_then_eval();
    check("t4_locked", 32'(locked), 32'h1);
    check("t4_offset", 32'(ooffset), 32'h6);

    // 5: asynchronous reset while locked, between edges
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_odata", 32'(odata), 32'h0);
    check("t5_valid", 32'(ovalid), 32'h0);
    check("t5_locked", 32'(locked), 32'h0);
    check("t5_offset", 32'(ooffset), 32'h0);
    check("t5_comma", 32'(comma_det), 32'h0);
`ifdef SYMBOL_ALIGNER_STATS_EN
    check("t5_loss_events", 32'(loss_events), 32'h0);
`endif

    // 6: 7-bit slip, payload passes through aligned with one symbol delay
    restart(7);
    for (int i = 0; i < 3; i++) begin
      fills(2 + (i == 0 ? 1 : 0));
      comma_then_eval();
    end
    check("t6_locked", 32'(locked), 32'h1);
    check("t6_offset", 32'(ooffset), 32'h7);
    feed(pay[0]);
    for (int i = 1; i < 5; i++) begin
      feed(pay[i]);
      check($sformatf("t6_pay%0d", i - 1), 32'(odata), 32'(pay[i - 1]));
      check($sformatf("t6_pay%0d_comma", i - 1), 32'(comma_det), 32'h0);
    end
    check("t6_valid", 32'(ovalid), 32'h1);

    // 7: boundary offset 0 (candidate is the previous word itself)
    restart(0);
    for (int i = 0; i < 3; i++) begin
      fills(2 + (i == 0 ? 1 : 0));
      comma_then_eval();
    end
    check("t7_locked", 32'(locked), 32'h1);
    check("t7_offset", 32'(ooffset), 32'h0);
    feed(Fill);
    check("t7_odata", 32'(odata), 32'(Fill));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
